// File: rtl/z80_bus_arbiter.sv
// Shares one synchronous memory port between a tv80n CPU and a DMA requester.
// Ownership moves only through the Z80 busrq_n/busak_n handshake.
module z80_bus_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CPU_GAP  = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic       busrq_n,
    input  logic       busak_n,
    input  logic [9:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    input  logic       cpu_mreq_n,
    input  logic       cpu_wr_n,
    input  logic       dma_req,
    input  logic       dma_stb,
    input  logic       dma_we,
    input  logic [9:0] dma_addr,
    input  logic [7:0] dma_wdata,
    output logic       dma_grant,
    output logic       dma_ack,
    output logic [7:0] dma_rdata,
    output logic       mem_we,
    output logic [9:0] mem_addr,
    output logic [7:0] mem_din,
    input  logic [7:0] mem_dout
);

    localparam int CW_RAW = $clog2(HOLD_MAX + 1);
    localparam int CW     = (CW_RAW > 4) ? CW_RAW : 4;
    localparam int GW_RAW = $clog2(CPU_GAP + 1);
    localparam int GW     = (GW_RAW > 1) ? GW_RAW : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
    localparam logic [GW-1:0] GAP_SAT   = GW'(CPU_GAP);

    typedef enum logic [1:0] {
        CPU_OWN,
        REQUEST,
        DMA_OWN,
        RELEASE
    } state_t;

    state_t        state;
    logic [CW-1:0] strb_cnt;
    logic [GW-1:0] gap_cnt;
    logic          accept;
    logic          gap_done;
    logic          cpu_write;

    // A strobe is only honoured while the CPU still has the bus floated.
    assign accept    = (state == DMA_OWN) && dma_stb && !busak_n;
    assign gap_done  = (gap_cnt >= GAP_SAT);
    assign cpu_write = !cpu_wr_n && !cpu_mreq_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CPU_OWN;
            busrq_n   <= 1'b1;
            dma_grant <= 1'b0;
            dma_ack   <= 1'b0;
            strb_cnt  <= '0;
            gap_cnt   <= GAP_SAT;
        end else begin
            dma_ack <= accept;
            case (state)
                CPU_OWN: begin
                    if (dma_req && gap_done) begin
                        state   <= REQUEST;
                        busrq_n <= 1'b0;
                        gap_cnt <= '0;
                    end else if (!gap_done) begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                REQUEST: begin
                    if (!dma_req) begin
                        state   <= CPU_OWN;
                        busrq_n <= 1'b1;
                    end else if (!busak_n) begin
                        state     <= DMA_OWN;
                        dma_grant <= 1'b1;
                        strb_cnt  <= '0;
                    end
                end
                DMA_OWN: begin
                    strb_cnt <= strb_cnt + CW'(accept);
                    // CPU reclaiming the bus, hold limit reached, or requester done.
                    if (busak_n || (accept && (strb_cnt == HOLD_LAST)) ||
                        (!dma_req && !dma_stb)) begin
                        state     <= RELEASE;
                        dma_grant <= 1'b0;
                        busrq_n   <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (busak_n) begin
                        state <= CPU_OWN;
                    end
                end
                default: begin
                    state     <= CPU_OWN;
                    busrq_n   <= 1'b1;
                    dma_grant <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr = cpu_addr;
        mem_din  = cpu_dout;
        mem_we   = 1'b0;
        case (state)
            CPU_OWN, REQUEST: mem_we = cpu_write;
            DMA_OWN: begin
                mem_addr = dma_addr;
                mem_din  = dma_wdata;
                mem_we   = accept && dma_we;
            end
            default: mem_we = 1'b0;
        endcase
    end

    // Memory read data arrives the cycle after the strobe, aligned with the ack.
    assign dma_rdata = dma_ack ? mem_dout : 8'h00;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed bench for z80_bus_arbiter: a vector table for the basic handshake and
// transfers, then hand-built sequences for hold limit, gap, abort, reset and bus violation.
module tb_z80_bus_arbiter;

    localparam int HOLD = 16;
    localparam int GAP  = 8;
    localparam int CA   = 'h120;

    logic       clk;
    logic       reset;
    logic       busrq_n;
    logic       busak_n;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_dout;
    logic       cpu_mreq_n;
    logic       cpu_wr_n;
    logic       dma_req;
    logic       dma_stb;
    logic       dma_we;
    logic [9:0] dma_addr;
    logic [7:0] dma_wdata;
    logic       dma_grant;
    logic       dma_ack;
    logic [7:0] dma_rdata;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    logic [7:0] mem [1024];

    int checks;
    int errors;
    int step_no;

    typedef struct {
        logic       rst, req, bk, stb, we, mreq_n, wr_n;
        logic [9:0] daddr;
        logic [7:0] wdata;
        logic       ebrq, egnt, eack, ewe;
        logic [9:0] eaddr;
        int         erd;
    } vec_t;

    vec_t vecs[$];

    z80_bus_arbiter #(.HOLD_MAX(HOLD), .CPU_GAP(GAP)) dut (
        .clk(clk), .reset(reset),
        .busrq_n(busrq_n), .busak_n(busak_n),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_mreq_n(cpu_mreq_n), .cpu_wr_n(cpu_wr_n),
        .dma_req(dma_req), .dma_stb(dma_stb), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_grant(dma_grant), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one cycle read latency.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    function automatic vec_t mkVec(input int rst, req, bk, stb, we, mreq, wr,
                                   daddr, wdata, ebrq, egnt, eack, ewe, eaddr, erd);
        vec_t v;
        v.rst = rst[0];   v.req = req[0];   v.bk = bk[0];   v.stb = stb[0];
        v.we = we[0];     v.mreq_n = mreq[0];   v.wr_n = wr[0];
        v.daddr = 10'(daddr);   v.wdata = 8'(wdata);
        v.ebrq = ebrq[0]; v.egnt = egnt[0]; v.eack = eack[0]; v.ewe = ewe[0];
        v.eaddr = 10'(eaddr);   v.erd = erd;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset      = v.rst;
        dma_req    = v.req;
        busak_n    = v.bk;
        dma_stb    = v.stb;
        dma_we     = v.we;
        cpu_mreq_n = v.mreq_n;
        cpu_wr_n   = v.wr_n;
        dma_addr   = v.daddr;
        dma_wdata  = v.wdata;
    endtask

    task automatic cmp(input string nm, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0h, want %0h", nm, step_no, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v);
        cmp("busrq_n",   10'(busrq_n),   10'(v.ebrq));
        cmp("dma_grant", 10'(dma_grant), 10'(v.egnt));
        cmp("dma_ack",   10'(dma_ack),   10'(v.eack));
        cmp("mem_we",    10'(mem_we),    10'(v.ewe));
        cmp("mem_addr",  mem_addr,       v.eaddr);
        if (v.erd >= 0) cmp("dma_rdata", 10'(dma_rdata), 10'(v.erd));
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        #2;
        checkOutput(v);
        @(posedge clk);
        #1;
        step_no++;
    endtask

    // Holds a request with the CPU running until busrq_n goes low, within a budget.
    task automatic waitRequest(input int max_cycles);
        bit seen;
        seen = 1'b0;
        applyStimulus(mkVec(0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, -1));
        for (int i = 0; i < max_cycles; i++) begin
            #2;
            if (busrq_n === 1'b0) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL request_timeout step %0d: got busrq_n %0b, want 0 within %0d cycles",
                     step_no, busrq_n, max_cycles);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        step_no  = 0;
        cpu_addr = 10'(CA);
        cpu_dout = 8'h5A;
        applyStimulus(mkVec(1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, CA, 0));
        repeat (2) @(posedge clk);
        #1;

        //                rst req bk stb we mrq wr  daddr  wdata  brq gnt ack we  addr   rdata
        vecs.push_back(mkVec(0, 0, 1, 0, 0, 1, 1, 'h000, 'h00,  1, 0, 0, 0, CA,    0));
        vecs.push_back(mkVec(0, 0, 1, 0, 0, 0, 0, 'h000, 'h00,  1, 0, 0, 1, CA,    0));
        vecs.push_back(mkVec(0, 1, 1, 0, 0, 1, 1, 'h000, 'h00,  1, 0, 0, 0, CA,    0));
        vecs.push_back(mkVec(0, 1, 1, 0, 0, 1, 1, 'h000, 'h00,  0, 0, 0, 0, CA,    0));
        vecs.push_back(mkVec(0, 1, 1, 0, 0, 1, 1, 'h000, 'h00,  0, 0, 0, 0, CA,    0));
        vecs.push_back(mkVec(0, 1, 1, 0, 0, 1, 1, 'h000, 'h00,  0, 0, 0, 0, CA,    0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 1, 1, 'h000, 'h00,  0, 0, 0, 0, CA,    0));
        vecs.push_back(mkVec(0, 1, 0, 1, 1, 1, 1, 'h005, 'hA5,  0, 1, 0, 1, 'h005, 0));
        vecs.push_back(mkVec(0, 1, 0, 1, 0, 1, 1, 'h005, 'h00,  0, 1, 1, 0, 'h005, -1));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 1, 1, 'h005, 'h00,  0, 1, 1, 0, 'h005, 'hA5));
        vecs.push_back(mkVec(0, 1, 0, 1, 0, 1, 1, 'h120, 'h00,  0, 1, 0, 0, 'h120, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 1, 1, 'h120, 'h00,  0, 1, 1, 0, 'h120, 'h5A));
        vecs.push_back(mkVec(0, 0, 0, 1, 1, 1, 1, 'h077, 'h33,  1, 0, 0, 0, CA,    0));
        vecs.push_back(mkVec(0, 0, 1, 0, 0, 1, 1, 'h000, 'h00,  1, 0, 0, 0, CA,    0));

        $display("[TB] table: %0d vectors", vecs.size());
        foreach (vecs[i]) runVec(vecs[i]);

        $display("[TB] CPU gap, then hold limit burst");
        for (int i = 0; i < GAP; i++)
            runVec(mkVec(0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, CA, 0));
        waitRequest(4);
        runVec(mkVec(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, CA, 0));
        for (int i = 0; i < HOLD; i++)
            runVec(mkVec(0, 1, 0, 1, 1, 1, 1, 'h40 + i, i, 0, 1, (i > 0) ? 1 : 0, 1, 'h40 + i, -1));
        runVec(mkVec(0, 1, 0, 1, 1, 1, 1, 'h3F0, 'hEE, 1, 0, 1, 0, CA, -1));
        runVec(mkVec(0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, CA, 0));
        for (int i = 0; i < GAP; i++)
            runVec(mkVec(0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, CA, 0));
        waitRequest(4);

        $display("[TB] request withdrawn before acknowledge");
        runVec(mkVec(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, CA, 0));
        runVec(mkVec(0, 0, 1, 1, 1, 1, 1, 'h010, 'h77, 1, 0, 0, 0, CA, 0));
        runVec(mkVec(0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, CA, 0));

        $display("[TB] reset during DMA ownership");
        waitRequest(GAP + 6);
        runVec(mkVec(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, CA, 0));
        runVec(mkVec(1, 1, 0, 1, 1, 1, 1, 'h0AA, 'h99, 0, 1, 0, 1, 'h0AA, -1));
        runVec(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, CA, 0));

        $display("[TB] immediate request after reset, then busak_n violation");
        runVec(mkVec(0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, CA, 0));
        runVec(mkVec(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, CA, 0));
        runVec(mkVec(0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        runVec(mkVec(0, 1, 0, 1, 1, 1, 1, 'h055, 'h12, 1, 0, 0, 0, CA, 0));
        runVec(mkVec(0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, CA, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
